// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer between the external req/ack handshake and the
// processor core. A rising edge on req picks a program slot, holds the
// core in reset for RST_CYC cycles, releases it, counts execution cycles,
// enforces a watchdog and returns ack with a status code.
//
// Handshake: a run starts on a rising edge of req (req high now, low on
// the previous clock) seen while idle or finished; req is ignored while
// busy. ack rises when the run ends and stays high until the next start
// event, and a falling req does not clear it. There is no ready/backpressure
// on either side: core_done is a level the core raises when finished.
//
// All outputs are registered. The FSM state is kept in the signal 'state'
// so checkers can bind to it directly.
module run_ctrl #(
    parameter int T       = 10,
    parameter int NPROG   = 4,
    parameter int SW      = 2,
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               init,
    input  logic               req,
    input  logic [SW-1:0]      prog_sel,
    input  logic [NPROG*T-1:0] base_addrs,
    input  logic               core_done,
    output logic               core_reset,
    output logic [T-1:0]       start_pc,
    output logic               busy,
    output logic               ack,
    output logic [1:0]         status,
    output logic [CW-1:0]      cycles
);

    // Width of the launch down-counter, large enough to hold RST_CYC.
    localparam int LW = $clog2(RST_CYC + 1);

    localparam logic [LW-1:0] LAUNCH_LOAD = LW'(RST_CYC);
    localparam logic [LW-1:0] LAUNCH_LAST = LW'(1);
    localparam logic [CW:0]   TIMEOUT_V   = (CW+1)'(TIMEOUT);
    localparam logic [SW:0]   NPROG_V     = (SW+1)'(NPROG);
    localparam logic [CW-1:0] CYC_MAX     = '1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BADSEL  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_d;

    logic            req_q;
    // Set once req has been seen low since init, so a request held high
    // straight through a reset cannot start a run on its own.
    logic            armed;
    logic            start_evt;

    logic [LW-1:0]   launch_cnt;
    logic [LW-1:0]   launch_cnt_d;

    logic            sel_ok;
    logic [T-1:0]    sel_pc;
    logic [CW:0]     cyc_inc;
    logic [CW-1:0]   cyc_sat;
    logic            timeout_hit;

    logic            core_reset_d;
    logic [T-1:0]    start_pc_d;
    logic            busy_d;
    logic            ack_d;
    logic [1:0]      status_d;
    logic [CW-1:0]   cycles_d;

    assign start_evt = req & ~req_q & armed;

    // Slot decode: validity check and entry-PC mux (NPROG need not be 2**SW).
    always_comb begin
        sel_ok = ({1'b0, prog_sel} < NPROG_V);
        sel_pc = '0;
        for (int k = 0; k < NPROG; k++) begin
            if (prog_sel == SW'(k)) begin
                sel_pc = base_addrs[k*T +: T];
            end
        end
    end

    // Cycle counter arithmetic: saturating increment and watchdog compare.
    // The compare is one bit wider than the counter so it cannot wrap.
    always_comb begin
        cyc_inc     = {1'b0, cycles} + 1'b1;
        cyc_sat     = (cycles == CYC_MAX) ? cycles : cyc_inc[CW-1:0];
        timeout_hit = (TIMEOUT != 0) && (cyc_inc == TIMEOUT_V);
    end

    // Next-state and next-output logic; outputs follow the next state.
    always_comb begin
        state_d      = state;
        launch_cnt_d = launch_cnt;
        start_pc_d   = start_pc;
        ack_d        = ack;
        status_d     = status;
        cycles_d     = cycles;

        case (state)
            IDLE, DONE, FAULT: begin
                if (start_evt) begin
                    cycles_d = '0;
                    if (sel_ok) begin
                        start_pc_d   = sel_pc;
                        ack_d        = 1'b0;
                        status_d     = ST_OK;
                        launch_cnt_d = LAUNCH_LOAD;
                        state_d      = LAUNCH;
                    end else begin
                        start_pc_d = '0;
                        ack_d      = 1'b1;
                        status_d   = ST_BADSEL;
                        state_d    = FAULT;
                    end
                end
            end
            LAUNCH: begin
                launch_cnt_d = launch_cnt - 1'b1;
                if (launch_cnt == LAUNCH_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The cycle in which core_done is seen is itself counted,
                // and a done in the same cycle as the watchdog wins.
                cycles_d = cyc_sat;
                if (core_done) begin
                    ack_d    = 1'b1;
                    status_d = ST_OK;
                    state_d  = DONE;
                end else if (timeout_hit) begin
                    ack_d    = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = FAULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d == LAUNCH) || (state_d == RUN);
        core_reset_d = (state_d != RUN);
    end

    // State and output registers; init overrides everything, even mid-run.
    always_ff @(posedge clk) begin
        if (init) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            armed      <= 1'b0;
            launch_cnt <= '0;
            core_reset <= 1'b1;
            start_pc   <= '0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            status     <= ST_OK;
            cycles     <= '0;
        end else begin
            state      <= state_d;
            req_q      <= req;
            armed      <= armed | ~req;
            launch_cnt <= launch_cnt_d;
            core_reset <= core_reset_d;
            start_pc   <= start_pc_d;
            busy       <= busy_d;
            ack        <= ack_d;
            status     <= status_d;
            cycles     <= cycles_d;
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl. Expected run results are
// queued when a run is launched and compared when ack reports the end.
module tb_run_ctrl;

    localparam int T       = 10;
    localparam int NPROG   = 3;
    localparam int SW      = 2;
    localparam int CW      = 16;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 1000;

    logic               clk;
    logic               init;
    logic               req;
    logic [SW-1:0]      prog_sel;
    logic [NPROG*T-1:0] base_addrs;
    logic               core_done;
    logic               core_reset;
    logic [T-1:0]       start_pc;
    logic               busy;
    logic               ack;
    logic [1:0]         status;
    logic [CW-1:0]      cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // {status, cycles, start_pc}
    logic [2+CW+T-1:0] exp_q[$];

    logic [T-1:0] slot_pc [NPROG];

    run_ctrl #(
        .T(T), .NPROG(NPROG), .SW(SW), .CW(CW),
        .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .init(init),
        .req(req),
        .prog_sel(prog_sel),
        .base_addrs(base_addrs),
        .core_done(core_done),
        .core_reset(core_reset),
        .start_pc(start_pc),
        .busy(busy),
        .ack(ack),
        .status(status),
        .cycles(cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [1:0] st, input logic [CW-1:0] cyc, input logic [T-1:0] pc);
        exp_q.push_back({st, cyc, pc});
    endtask

    task automatic sb_compare();
        logic [2+CW+T-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check("sb_status",   32'(status),   32'(e[2+CW+T-1 -: 2]));
            check("sb_cycles",   32'(cycles),   32'(e[CW+T-1 -: CW]));
            check("sb_start_pc", 32'(start_pc), 32'(e[T-1:0]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Raise req with the given slot, check the launch phase, and return at
    // the first negedge on which the core is out of reset.
    task automatic launch(input logic [SW-1:0] sel, input logic [T-1:0] exp_pc, input bit keep_req);
        int  cnt;
        bit  ok;
        @(negedge clk);
        prog_sel = sel;
        req      = 1'b1;
        @(negedge clk);
        if (!keep_req) req = 1'b0;
        check("launch_busy",     32'(busy),     1);
        check("launch_ack_drop", 32'(ack),      0);
        check("launch_start_pc", 32'(start_pc), 32'(exp_pc));
        check("launch_cycles",   32'(cycles),   0);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (core_reset == 1'b0) begin
                ok = 1'b1;
                break;
            end
            cnt++;
            @(negedge clk);
        end
        if (!ok) check("release_seen", 0, 1);
        check("launch_len", 32'(cnt), 32'(RST_CYC));
        check("run_busy",   32'(busy), 1);
    endtask

    // Called at the release negedge: core_done is seen on RUN edge n.
    task automatic run_done(input int n);
        repeat (n - 1) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_ack",        32'(ack),        1);
        check("done_busy",       32'(busy),       0);
        check("done_core_reset", 32'(core_reset), 1);
        sb_compare();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit bad;
        int k;
        logic [SW-1:0] sel;
        int n;

        init      = 1'b1;
        req       = 1'b0;
        prog_sel  = '0;
        core_done = 1'b0;
        slot_pc[0] = T'($urandom_range(1, 1023));
        slot_pc[1] = T'($urandom_range(1, 1023));
        slot_pc[2] = 10'h120;
        base_addrs = {slot_pc[2], slot_pc[1], slot_pc[0]};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_busy",       32'(busy),       0);
        check("rst_ack",        32'(ack),        0);
        check("rst_status",     32'(status),     0);
        check("rst_cycles",     32'(cycles),     0);
        check("rst_start_pc",   32'(start_pc),   0);
        init = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // slot 2, done after 50 RUN cycles, req held high afterwards
        push_exp(2'b00, 16'd50, 10'h120);
        launch(2'd2, 10'h120, 1'b1);
        run_done(50);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || !ack) bad = 1'b1;
        end
        check("held_req_no_restart", 32'(bad), 0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check("req_fall_ack_holds",    32'(ack),    1);
        check("req_fall_status_holds", 32'(status), 0);

        // slot 1, core never finishes -> watchdog
        push_exp(2'b01, 16'(TIMEOUT), slot_pc[1]);
        launch(2'd1, slot_pc[1], 1'b0);
        k = 0;
        for (int i = 0; i < TIMEOUT + 100; i++) begin
            @(negedge clk);
            k++;
            if (ack) break;
        end
        check("timeout_latency",    32'(k),          32'(TIMEOUT));
        check("timeout_core_reset", 32'(core_reset), 1);
        check("timeout_busy",       32'(busy),       0);
        sb_compare();

        // bad select
        push_exp(2'b10, '0, '0);
        @(negedge clk);
        prog_sel = 2'd3;
        req      = 1'b1;
        @(negedge clk);
        check("badsel_ack",        32'(ack),        1);
        check("badsel_core_reset", 32'(core_reset), 1);
        check("badsel_busy",       32'(busy),       0);
        sb_compare();
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            req = 1'b0;
            if (busy || !core_reset) bad = 1'b1;
        end
        check("badsel_never_busy", 32'(bad), 0);

        // init pulse at RUN cycle 20 with req held high
        launch(2'd0, slot_pc[0], 1'b1);
        repeat (19) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("midrun_rst_core_reset", 32'(core_reset), 1);
        check("midrun_rst_busy",       32'(busy),       0);
        check("midrun_rst_ack",        32'(ack),        0);
        check("midrun_rst_status",     32'(status),     0);
        check("midrun_rst_cycles",     32'(cycles),     0);
        check("midrun_rst_start_pc",   32'(start_pc),   0);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy || ack || !core_reset) bad = 1'b1;
        end
        check("held_req_after_init", 32'(bad), 0);
        req = 1'b0;

        // a few randomised runs
        repeat (3) begin
            sel = SW'($urandom_range(0, NPROG - 1));
            n   = $urandom_range(1, 200);
            push_exp(2'b00, CW'(n), slot_pc[sel]);
            launch(sel, slot_pc[sel], 1'b0);
            run_done(n);
        end

        // relaunch from DONE; done coincides with the watchdog cycle
        push_exp(2'b00, 16'(TIMEOUT), slot_pc[0]);
        launch(2'd0, slot_pc[0], 1'b1);
        run_done(TIMEOUT);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || !ack) bad = 1'b1;
        end
        check("final_no_second_start", 32'(bad), 0);
        check("final_status",          32'(status), 0);
        check("sb_drained",            32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
